// File: rtl/ddr_rd_capture.sv
// Read-return capture: queues issued CAS_R commands, checks the read preamble at the due
// cycle, gathers the burst beats and returns one assembled word with its address.
module ddr_rd_capture #(
  parameter int DQ_W   = 64,
  parameter int ADDR_W = 32,
  parameter int PEND_D = 8,
  parameter int CNT_W  = 10
) (
  input  logic                clock_t,
  input  logic                reset,
  input  logic                cas_rd_valid,
  input  logic [ADDR_W-1:0]   cas_rd_addr,
  input  logic [7:0]          rd_delay,
  input  logic [3:0]          burst_length,
  input  logic [1:0]          rd_pre,
  input  logic [DQ_W-1:0]     dq_in,
  input  logic                dqs_t_in,
  input  logic                dqs_c_in,
  output logic                rd_valid,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [8*DQ_W-1:0]   rd_data,
  output logic                rd_err,
  output logic                pend_full,
  output logic [3:0]          pend_count
);

  localparam int PW = $clog2(PEND_D);

  typedef enum logic [1:0] {IDLE, PRE, BURST, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cyc;

  logic [CNT_W-1:0]    due_mem  [PEND_D];
  logic [ADDR_W-1:0]   addr_mem [PEND_D];
  logic [3:0]          bl_mem   [PEND_D];
  logic [1:0]          pre_mem  [PEND_D];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [3:0]          count;

  logic                push, head_due, start, drop;
  logic                pre_ok, strobe_ok, last_beat;
  logic [1:0]          head_pre;

  logic [ADDR_W-1:0]   cur_addr, drop_addr;
  logic [3:0]          cur_bl;
  logic [1:0]          pre_cnt;
  logic [2:0]          beat;
  logic                err, drop_pend;
  logic [8*DQ_W-1:0]   beat_buf, beat_ins;

  assign pend_full  = (count == 4'(PEND_D));
  assign pend_count = count;
  assign push       = cas_rd_valid && !pend_full;
  assign head_due   = (count != 4'd0) && (due_mem[rd_ptr] == cyc);
  assign head_pre   = pre_mem[rd_ptr];
  // The due cycle itself is the first preamble cycle, so a burst can start from IDLE or DONE.
  assign start      = head_due && ((state == IDLE) || (state == DONE));
  assign drop       = head_due && !((state == IDLE) || (state == DONE));
  assign pre_ok     = !dqs_t_in && dqs_c_in;
  assign strobe_ok  = (dqs_t_in != dqs_c_in);
  assign last_beat  = (state == BURST) && ({1'b0, beat} == (cur_bl - 4'd1));

  always_comb begin
    beat_ins = beat_buf;
    beat_ins[int'(beat)*DQ_W +: DQ_W] = dq_in;
  end

  always_ff @(posedge clock_t) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 1'b1;
  end

  // Outstanding-read FIFO
  always_ff @(posedge clock_t) begin
    if (push) begin
      due_mem[wr_ptr]  <= cyc + CNT_W'(rd_delay);
      addr_mem[wr_ptr] <= cas_rd_addr;
      bl_mem[wr_ptr]   <= burst_length;
      pre_mem[wr_ptr]  <= rd_pre;
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (head_due) rd_ptr <= rd_ptr + 1'b1;
      case ({push, head_due})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (head_pre <= 2'd1) ? BURST : PRE;
        else       state_nxt = IDLE;
      end
      PRE:     if (pre_cnt == 2'd1) state_nxt = BURST;
      BURST:   if (last_beat)       state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture control and result registers
  always_ff @(posedge clock_t) begin
    if (reset) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      beat      <= '0;
      err       <= 1'b0;
      drop_pend <= 1'b0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (start) begin
        pre_cnt <= head_pre - 2'd1;
        beat    <= '0;
        err     <= !pre_ok;
      end else if (state == PRE) begin
        pre_cnt <= pre_cnt - 2'd1;
        err     <= err | !pre_ok;
      end else if (state == BURST) begin
        beat    <= beat + 3'd1;
        err     <= err | !strobe_ok;
      end
      if (last_beat) begin
        rd_valid <= 1'b1;
        rd_data  <= beat_ins;
        rd_addr  <= cur_addr;
        rd_err   <= err | !strobe_ok;
      end else if ((state == DONE) && drop_pend) begin
        rd_valid  <= 1'b1;
        rd_data   <= '0;
        rd_addr   <= drop_addr;
        rd_err    <= 1'b1;
        drop_pend <= 1'b0;
      end
      if (drop) drop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clock_t) begin
    if (start) begin
      cur_addr <= addr_mem[rd_ptr];
      cur_bl   <= bl_mem[rd_ptr];
      beat_buf <= '0;
    end else if (state == BURST) begin
      beat_buf <= beat_ins;
    end
    if (drop) drop_addr <= addr_mem[rd_ptr];
  end

endmodule
